// File: rtl/latch_bank_arbiter.sv
// ---------------------------------------------------------------------------
// latch_bank_arbiter
//
// Round-robin controller that lets NREQ requesters share one WIDTH-bit
// storage register. A winner is picked in IDLE, the register is loaded with
// the winner's data slice in a single LOAD cycle (le pulse), the value is held
// frozen for HOLD cycles, and then the transfer is acknowledged. The ack stays
// high until the winner drops its request.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [NREQ]        level request per requester
//   din    in   [NREQ*WIDTH]  packed data, slice i = din[i*WIDTH +: WIDTH]
//   gnt    out  [NREQ]        one-hot grant (registered)
//   ack    out  [NREQ]        one-hot completion acknowledge (registered)
//   le     out                one-cycle load-enable pulse (registered)
//   q      out  [WIDTH]       stored value
//   owner  out  [log2 NREQ]   index of current / last granted requester
//   busy   out                high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module latch_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     din,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic                      le,
    output logic [WIDTH-1:0]          q,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    // HOLD is limited to 0..15, so a 4-bit down-counter is enough.
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              le_q, le_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [IW-1:0]     win_idx;
    logic              req_w;
    logic [IW-1:0]     ptr_inc;
    logic [WIDTH-1:0]  din_w;

    // First set request bit found when scanning p, p+1, ... modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    assign win_idx = rr_pick(req, ptr_q);
    assign req_w   = req[owner_q];
    assign din_w   = din[int'(owner_q)*WIDTH +: WIDTH];
    // Explicit wrap so non-power-of-two NREQ also returns to 0.
    assign ptr_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // Next-state and next-output logic of the transfer sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        le_d    = 1'b0;
        busy_d  = busy_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_LOAD;
                    owner_d = win_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    le_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD: begin
                // The capture happens even when the request is withdrawn.
                q_d = din_w;
                if (!req_w) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ack_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                end else if (HOLD > 0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD - 1);
                end else begin
                    state_d = S_RELEASE;
                    ack_d   = gnt_q;
                end
            end

            S_HOLD: begin
                // A withdrawn request aborts the transfer before any ack.
                if (!req_w) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ack_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                end else if (cnt_q == '0) begin
                    state_d = S_RELEASE;
                    ack_d   = gnt_q;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end

            S_RELEASE: begin
                if (!req_w) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ack_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                end else begin
                    state_d = S_RELEASE;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ack_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            le_q    <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            le_q    <= le_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign le    = le_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_latch_bank_arbiter
//
// Self-checking bench for latch_bank_arbiter (NREQ=4, WIDTH=4, HOLD=2).
// A transaction-level reference model tracks "is a transfer active, who won,
// how many cycles since the grant decision" and derives every output from
// that age. A compare process checks all outputs against the model on each
// falling clock edge. Directed scenarios add literal expectations; a long
// randomized phase with occasional asynchronous resets follows.
// ---------------------------------------------------------------------------
module tb_latch_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int HOLD  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  le;
    logic [WIDTH-1:0]      q;
    logic [1:0]            owner;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               m_active;
    int               m_w;
    int               m_age;     // cycles since the arbitration edge (1 = LOAD)
    int               m_ptr;
    int               m_owner;
    logic [WIDTH-1:0] m_q;

    latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .ack   (ack),
        .le    (le),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_w      = 0;
        m_age    = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_q      = '0;
    endtask

    // One rising edge of the reference model, using the inputs seen at that edge.
    task automatic model_step();
        if (!m_active) begin
            if (req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (req[i]) begin
                        m_w = i;
                        break;
                    end
                end
                m_active = 1'b1;
                m_age    = 1;
                m_owner  = m_w;
            end
        end else begin
            if (m_age == 1) m_q = din[m_w*WIDTH +: WIDTH];
            if (!req[m_w]) begin
                m_active = 1'b0;
                m_ptr    = (m_w + 1) % NREQ;
            end else if (m_age < 2 + HOLD) begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Asynchronous reset in the middle of the clock-low phase, checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp("rst_gnt",   32'(gnt),   32'h0);
        cmp("rst_ack",   32'(ack),   32'h0);
        cmp("rst_le",    32'(le),    32'h0);
        cmp("rst_q",     32'(q),     32'h0);
        cmp("rst_owner", 32'(owner), 32'h0);
        cmp("rst_busy",  32'(busy),  32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin : compare_proc
        logic [NREQ-1:0] oh;
        oh = m_active ? ({{(NREQ-1){1'b0}}, 1'b1} << m_w) : '0;
        cmp("gnt",   32'(gnt),   32'(oh));
        cmp("ack",   32'(ack),   32'((m_active && m_age >= 2 + HOLD) ? oh : '0));
        cmp("le",    32'(le),    32'(m_active && m_age == 1));
        cmp("q",     32'(q),     32'(m_q));
        cmp("owner", 32'(owner), 32'(m_owner));
        cmp("busy",  32'(busy),  32'(m_active));
    end

    initial begin
        logic [NREQ-1:0]  e;
        logic [WIDTH-1:0] qexp [NREQ];
        qexp = '{4'b1100, 4'b1111, 4'b0001, 4'b0010};

        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #4;
        rst_n = 1'b1;

        // Reset, then idle with no requests
        do_reset();
        tick();
        tick();
        cmp("idle_gnt",  32'(gnt),  32'h0);
        cmp("idle_busy", 32'(busy), 32'h0);
        cmp("idle_q",    32'(q),    32'h0);

        // Single request: latency and handshake
        din = 16'h000A;
        req = 4'b0001;
        tick();
        cmp("t2_gnt",  32'(gnt),  32'h1);
        cmp("t2_le",   32'(le),   32'h1);
        cmp("t2_busy", 32'(busy), 32'h1);
        tick();
        cmp("t2_q",    32'(q),    32'hA);
        cmp("t2_le0",  32'(le),   32'h0);
        cmp("t2_ack2", 32'(ack),  32'h0);
        tick();
        cmp("t2_ack3", 32'(ack),  32'h0);
        tick();
        cmp("t2_ack4", 32'(ack),  32'h1);
        tick();
        cmp("t2_ackh", 32'(ack),  32'h1);
        req = 4'b0000;
        tick();
        cmp("t2_gnt0",  32'(gnt),   32'h0);
        cmp("t2_ack0",  32'(ack),   32'h0);
        cmp("t2_busy0", 32'(busy),  32'h0);
        cmp("t2_owner", 32'(owner), 32'h0);

        // Round-robin fairness from pointer 0, then wrap
        do_reset();
        din = 16'h21FC;
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            e = 4'b0001 << k;
            tick();
            cmp("t3_gnt", 32'(gnt), 32'(e));
            tick();
            cmp("t3_q",   32'(q),   32'(qexp[k]));
            tick();
            tick();
            cmp("t3_ack", 32'(ack), 32'(e));
            req[k] = 1'b0;
            tick();
            cmp("t3_busy0", 32'(busy), 32'h0);
        end
        req = 4'b1111;
        tick();
        cmp("t3_wrap", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        cmp("t3_abort_q", 32'(q), 32'hC);

        // Frozen value while slice 2 changes
        din = 16'h0A00;
        req = 4'b0100;
        tick();
        cmp("t4_gnt", 32'(gnt), 32'h4);
        tick();
        cmp("t4_q0", 32'(q), 32'hA);
        din = 16'h0500;
        tick();
        cmp("t4_q1", 32'(q), 32'hA);
        din = 16'h0A00;
        tick();
        cmp("t4_q2", 32'(q), 32'hA);
        cmp("t4_ack", 32'(ack), 32'h4);
        din = 16'h0500;
        tick();
        cmp("t4_q3", 32'(q), 32'hA);
        req = 4'b0000;
        tick();

        // Abort in the first HOLD cycle, then wrapped search from pointer 3
        din = 16'h0300;
        req = 4'b0100;
        tick();
        cmp("t5_gnt", 32'(gnt), 32'h4);
        tick();
        req = 4'b0000;
        tick();
        cmp("t5_ack",  32'(ack),  32'h0);
        cmp("t5_busy", 32'(busy), 32'h0);
        cmp("t5_q",    32'(q),    32'h3);
        req = 4'b0110;
        tick();
        cmp("t5_gnt2", 32'(gnt), 32'h2);
        tick();
        tick();
        tick();
        cmp("t5_ack2", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();

        // Reset in the middle of HOLD, then a fresh grant from pointer 0
        din = 16'h00B0;
        req = 4'b0010;
        tick();
        tick();
        do_reset();
        tick();
        cmp("t6_gnt", 32'(gnt), 32'h2);
        cmp("t6_le",  32'(le),  32'h1);
        tick();
        cmp("t6_q",   32'(q),   32'hB);
        tick();
        tick();
        cmp("t6_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            din = 16'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (m_active && i == m_w) begin
                    if (m_age >= 2 + HOLD) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
